// File: rtl/rx_block_lock_fsm.sv
// ---------------------------------------------------------------------------
// rx_block_lock_fsm
//
// Block-alignment controller for the 128b/130b receive path. It hunts for a
// run of GOOD_TO_LOCK valid sync headers, requesting a one-bit slip from the
// upstream aligner whenever a bad header is seen while unlocked. Once locked,
// it counts bad headers per WIN_SIZE-header window and drops lock when
// BAD_TO_UNLOCK bad headers land inside one window.
//
// Input qualification: hdr_valid marks the cycle in which one block's sync
// header has been evaluated; hdr_bad is only looked at when hdr_valid is
// high. There is no backpressure -- a header may arrive every cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   hdr_valid   a sync header result is present this cycle
//   hdr_bad     that sync header was invalid (2'b00 / 2'b11)
//   slip        one-cycle pulse: shift block boundary by one bit
//   block_lock  block alignment achieved (gates payload consumption)
//   lock_lost   one-cycle pulse when lock is dropped
//   slip_count  saturating count of slip pulses since reset
//   state_dbg   current FSM state (HUNT=0, SLIP_WAIT=1, LOCKED=2)
// ---------------------------------------------------------------------------
module rx_block_lock_fsm #(
    parameter int GOOD_TO_LOCK  = 64,
    parameter int WIN_SIZE      = 1024,
    parameter int BAD_TO_UNLOCK = 16,
    parameter int SLIP_WAIT     = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hdr_valid,
    input  logic        hdr_bad,
    output logic        slip,
    output logic        block_lock,
    output logic        lock_lost,
    output logic [15:0] slip_count,
    output logic [1:0]  state_dbg
);

    localparam int GW = $clog2(GOOD_TO_LOCK + 1);
    localparam int WW = $clog2(WIN_SIZE + 1);
    localparam int BW = $clog2(BAD_TO_UNLOCK + 1);
    localparam int SW = $clog2(SLIP_WAIT + 1);

    // Each counter is compared against its limit minus one, so the
    // transition fires on the header/cycle that would make it reach the limit.
    localparam logic [GW-1:0] GOOD_LAST = GW'(GOOD_TO_LOCK - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WIN_SIZE - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_TO_UNLOCK - 1);
    localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);

    localparam logic [1:0] ST_HUNT      = 2'd0;
    localparam logic [1:0] ST_SLIP_WAIT = 2'd1;
    localparam logic [1:0] ST_LOCKED    = 2'd2;

    logic [1:0]    state;
    logic [GW-1:0] good_cnt;
    logic [WW-1:0] win_cnt;
    logic [BW-1:0] bad_cnt;
    logic [SW-1:0] wait_cnt;

    logic good_hdr;
    logic bad_hdr;
    logic unlock_fire;
    logic slip_fire;

    assign good_hdr = hdr_valid & ~hdr_bad;
    assign bad_hdr  = hdr_valid & hdr_bad;

    // Unlock is checked before the window-complete condition, so a header
    // that both closes the window and hits the bad limit still drops lock.
    assign unlock_fire = (state == ST_LOCKED) && bad_hdr && (bad_cnt == BAD_LAST);
    assign slip_fire   = ((state == ST_HUNT) && bad_hdr) || unlock_fire;

    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_HUNT;
            good_cnt   <= '0;
            win_cnt    <= '0;
            bad_cnt    <= '0;
            wait_cnt   <= '0;
            slip       <= 1'b0;
            block_lock <= 1'b0;
            lock_lost  <= 1'b0;
            slip_count <= 16'd0;
        end else begin
            slip      <= slip_fire;
            lock_lost <= unlock_fire;
            if (slip_fire && (slip_count != 16'hFFFF)) begin
                slip_count <= slip_count + 16'd1;
            end

            case (state)
                ST_HUNT: begin
                    if (bad_hdr) begin
                        good_cnt <= '0;
                        wait_cnt <= '0;
                        state    <= ST_SLIP_WAIT;
                    end else if (good_hdr) begin
                        if (good_cnt == GOOD_LAST) begin
                            good_cnt   <= '0;
                            win_cnt    <= '0;
                            bad_cnt    <= '0;
                            block_lock <= 1'b1;
                            state      <= ST_LOCKED;
                        end else begin
                            good_cnt <= good_cnt + GW'(1);
                        end
                    end
                end

                // Counts clock cycles; header inputs are deliberately ignored
                // while the aligner settles on the new boundary.
                ST_SLIP_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        good_cnt <= '0;
                        state    <= ST_HUNT;
                    end else begin
                        wait_cnt <= wait_cnt + SW'(1);
                    end
                end

                ST_LOCKED: begin
                    if (hdr_valid) begin
                        if (unlock_fire) begin
                            block_lock <= 1'b0;
                            win_cnt    <= '0;
                            bad_cnt    <= '0;
                            wait_cnt   <= '0;
                            state      <= ST_SLIP_WAIT;
                        end else if (win_cnt == WIN_LAST) begin
                            win_cnt <= '0;
                            bad_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + WW'(1);
                            if (hdr_bad) begin
                                bad_cnt <= bad_cnt + BW'(1);
                            end
                        end
                    end
                end

                default: begin
                    state      <= ST_HUNT;
                    block_lock <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_block_lock_fsm.sv
// ---------------------------------------------------------------------------
// tb_rx_block_lock_fsm
//
// Two instances: "a" with default parameters, "b" with tiny parameters
// (GOOD_TO_LOCK=2, WIN_SIZE=4, BAD_TO_UNLOCK=1, SLIP_WAIT=1) on a fast clock
// for the window-boundary priority case and slip_count saturation.
// The reference model works on header events and absolute cycle stamps:
// after a slip, headers are ignored until cycle (slip_cycle + SLIP_WAIT + 1).
// ---------------------------------------------------------------------------
module tb_rx_block_lock_fsm;

    localparam int A_G = 64, A_W = 1024, A_B = 16, A_S = 16;
    localparam int B_G = 2,  B_W = 4,    B_B = 1,  B_S = 1;
    localparam logic [1:0] ST_HUNT = 2'd0, ST_SLIP_WAIT = 2'd1;

    logic clk_a = 1'b0, clk_b = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    logic hdr_valid_a = 1'b0, hdr_bad_a = 1'b0;
    logic hdr_valid_b = 1'b0, hdr_bad_b = 1'b0;
    logic slip_a, block_lock_a, lock_lost_a, slip_b, block_lock_b, lock_lost_b;
    logic [15:0] slip_count_a, slip_count_b;
    logic [1:0]  state_a, state_b;
    logic [18:0] act_a, act_b;

    assign act_a = {slip_a, block_lock_a, lock_lost_a, slip_count_a};
    assign act_b = {slip_b, block_lock_b, lock_lost_b, slip_count_b};

    int checks = 0;
    int errors = 0;

    // Clock / reset
    always #5 clk_a = ~clk_a;
    always #1 clk_b = ~clk_b;

    rx_block_lock_fsm #(
        .GOOD_TO_LOCK(A_G), .WIN_SIZE(A_W), .BAD_TO_UNLOCK(A_B), .SLIP_WAIT(A_S)
    ) dut_a (
        .clk(clk_a), .rst(rst_a), .hdr_valid(hdr_valid_a), .hdr_bad(hdr_bad_a),
        .slip(slip_a), .block_lock(block_lock_a), .lock_lost(lock_lost_a),
        .slip_count(slip_count_a), .state_dbg(state_a)
    );

    rx_block_lock_fsm #(
        .GOOD_TO_LOCK(B_G), .WIN_SIZE(B_W), .BAD_TO_UNLOCK(B_B), .SLIP_WAIT(B_S)
    ) dut_b (
        .clk(clk_b), .rst(rst_b), .hdr_valid(hdr_valid_b), .hdr_bad(hdr_bad_b),
        .slip(slip_b), .block_lock(block_lock_b), .lock_lost(lock_lost_b),
        .slip_count(slip_count_b), .state_dbg(state_b)
    );

    // Reference model (index 0 = instance a, 1 = instance b)
    int p_g[2] = '{A_G, B_G};
    int p_w[2] = '{A_W, B_W};
    int p_b[2] = '{A_B, B_B};
    int p_s[2] = '{A_S, B_S};
    int m_good[2], m_win[2], m_bad[2], m_cyc[2], m_resume[2], m_slips[2];
    bit m_lock[2], m_slip[2], m_lost[2];

    logic [18:0] exp_q_a[$];
    logic [18:0] exp_q_b[$];

    task automatic model_reset(input int id);
        m_good[id] = 0; m_win[id] = 0; m_bad[id] = 0;
        m_cyc[id] = 0; m_resume[id] = 0; m_slips[id] = 0;
        m_lock[id] = 1'b0; m_slip[id] = 1'b0; m_lost[id] = 1'b0;
    endtask

    task automatic model_slip(input int id);
        m_slip[id] = 1'b1;
        m_slips[id]++;
        m_good[id] = 0;
        m_resume[id] = m_cyc[id] + p_s[id] + 1;
    endtask

    task automatic model_step(input int id, input bit v, input bit b);
        m_slip[id] = 1'b0;
        m_lost[id] = 1'b0;
        if (v && m_cyc[id] >= m_resume[id]) begin
            if (!m_lock[id]) begin
                if (b) begin
                    model_slip(id);
                end else begin
                    m_good[id]++;
                    if (m_good[id] == p_g[id]) begin
                        m_lock[id] = 1'b1;
                        m_good[id] = 0; m_win[id] = 0; m_bad[id] = 0;
                    end
                end
            end else begin
                m_win[id]++;
                if (b) m_bad[id]++;
                if (m_bad[id] == p_b[id]) begin
                    m_lock[id] = 1'b0;
                    m_lost[id] = 1'b1;
                    model_slip(id);
                end else if (m_win[id] == p_w[id]) begin
                    m_win[id] = 0;
                    m_bad[id] = 0;
                end
            end
        end
        m_cyc[id]++;
    endtask

    function automatic logic [18:0] exp_vec(input int id);
        int sc;
        sc = (m_slips[id] > 65535) ? 65535 : m_slips[id];
        return {m_slip[id], m_lock[id], m_lost[id], 16'(sc)};
    endfunction

    // Drivers: inputs change at the falling edge, outputs are checked at the
    // next falling edge.
    task automatic step_a(input bit v, input bit b);
        hdr_valid_a = v;
        hdr_bad_a   = b;
        @(posedge clk_a);
        model_step(0, v, b);
        exp_q_a.push_back(exp_vec(0));
        @(negedge clk_a);
    endtask

    task automatic step_b(input bit v, input bit b);
        hdr_valid_b = v;
        hdr_bad_b   = b;
        @(posedge clk_b);
        model_step(1, v, b);
        exp_q_b.push_back(exp_vec(1));
        @(negedge clk_b);
    endtask

    task automatic reset_a();
        @(negedge clk_a);
        rst_a = 1'b1; hdr_valid_a = 1'b0; hdr_bad_a = 1'b0;
        exp_q_a.delete();
        @(negedge clk_a);
        rst_a = 1'b0;
        model_reset(0);
    endtask

    task automatic reset_b();
        @(negedge clk_b);
        rst_b = 1'b1; hdr_valid_b = 1'b0; hdr_bad_b = 1'b0;
        exp_q_b.delete();
        @(negedge clk_b);
        rst_b = 1'b0;
        model_reset(1);
    endtask

    // Tests
    task automatic test_reset();
        repeat (3) @(negedge clk_a);
        checks++;
        if ({act_a, state_a} !== {19'd0, ST_HUNT}) begin
            errors++;
            $display("FAIL reset_a got %h/%0d exp 0/%0d", act_a, state_a, ST_HUNT);
        end
        checks++;
        if ({act_b, state_b} !== {19'd0, ST_HUNT}) begin
            errors++;
            $display("FAIL reset_b got %h/%0d exp 0/%0d", act_b, state_b, ST_HUNT);
        end
        rst_a = 1'b0;
        model_reset(0);
        @(negedge clk_b);
        rst_b = 1'b0;
        model_reset(1);
    endtask

    task automatic test_lock_acquire();
        logic [18:0] exp;
        int goods = 0;
        int cyc = 0;
        // Good headers with random idle gaps; hdr_bad is noise when idle.
        while (goods < A_G) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            step_a(v, v ? 1'b0 : 1'($urandom_range(0, 1)));
            if (v) goods++;
            exp = exp_q_a.pop_front();
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL lock_acquire cyc %0d got %h exp %h", cyc, act_a, exp);
            end
            checks++;
            if (block_lock_a !== (goods == A_G)) begin
                errors++;
                $display("FAIL lock_acquire_edge cyc %0d got %b exp %b", cyc, block_lock_a, goods == A_G);
            end
            cyc++;
        end
        checks++;
        if (slip_count_a !== 16'd0) begin
            errors++;
            $display("FAIL lock_acquire_slips got %0d exp 0", slip_count_a);
        end
    endtask

    task automatic test_hunt_slip();
        logic [18:0] exp;
        int slips_seen = 0;
        reset_a();
        for (int i = 0; i < 10 + 1 + A_S + A_G; i++) begin
            if (i < 10)              step_a(1'b1, 1'b0);
            else if (i == 10)        step_a(1'b1, 1'b1);
            else if (i < 11 + A_S)   step_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else                     step_a(1'b1, 1'b0);
            exp = exp_q_a.pop_front();
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL hunt_slip cyc %0d got %h exp %h", i, act_a, exp);
            end
            if (slip_a) slips_seen++;
        end
        checks++;
        if ({slips_seen, block_lock_a, slip_count_a} !== {32'd1, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL hunt_slip_final got slips=%0d lock=%b cnt=%0d exp 1/1/1",
                     slips_seen, block_lock_a, slip_count_a);
        end
    endtask

    task automatic test_loss_of_lock();
        logic [18:0] exp;
        bit bp[1000];
        int n = 0;
        int lost_n = 0;
        int slip_n = 0;
        bp = '{default: 1'b0};
        while (n < A_B) begin
            int p;
            p = $urandom_range(0, 999);
            if (!bp[p]) begin bp[p] = 1'b1; n++; end
        end
        for (int i = 0; i < 1000; i++) begin
            step_a(1'b1, bp[i]);
            exp = exp_q_a.pop_front();
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL loss_of_lock hdr %0d got %h exp %h", i, act_a, exp);
            end
            if (slip_a) slip_n++;
            if (lock_lost_a) begin
                lost_n++;
                checks++;
                if ({block_lock_a, slip_a, state_a} !== {1'b0, 1'b1, ST_SLIP_WAIT}) begin
                    errors++;
                    $display("FAIL loss_of_lock_state got lock=%b slip=%b st=%0d exp 0/1/%0d",
                             block_lock_a, slip_a, state_a, ST_SLIP_WAIT);
                end
            end
        end
        checks++;
        if (lost_n != 1 || slip_n != 1) begin
            errors++;
            $display("FAIL loss_of_lock_pulses got lost=%0d slip=%0d exp 1/1", lost_n, slip_n);
        end
    endtask

    task automatic test_window_reset();
        logic [18:0] exp;
        bit bp[1024];
        int lost_n = 0;
        reset_a();
        for (int i = 0; i < A_G; i++) begin
            step_a(1'b1, 1'b0);
            exp = exp_q_a.pop_front();
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL window_lock cyc %0d got %h exp %h", i, act_a, exp);
            end
        end
        for (int w = 0; w < 2; w++) begin
            int n = 0;
            bp = '{default: 1'b0};
            while (n < A_B - 1) begin
                int p;
                p = $urandom_range(0, A_W - 1);
                if (!bp[p]) begin bp[p] = 1'b1; n++; end
            end
            for (int i = 0; i < A_W; i++) begin
                step_a(1'b1, bp[i]);
                exp = exp_q_a.pop_front();
                checks++;
                if (act_a !== exp || block_lock_a !== 1'b1) begin
                    errors++;
                    $display("FAIL window_reset w%0d hdr %0d got %h exp %h", w, i, act_a, exp);
                end
                if (lock_lost_a) lost_n++;
            end
        end
        checks++;
        if (lost_n != 0) begin
            errors++;
            $display("FAIL window_reset_lost got %0d exp 0", lost_n);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [18:0] exp;
        reset_a();
        // Reset during the slip cycle itself: the pulse must vanish at once.
        step_a(1'b1, 1'b1);
        exp = exp_q_a.pop_front();
        checks++;
        if (act_a !== exp || slip_a !== 1'b1) begin
            errors++;
            $display("FAIL reset_wait_slip got %h exp %h", act_a, exp);
        end
        #1 rst_a = 1'b1;
        #1;
        checks++;
        if ({act_a, state_a} !== {19'd0, ST_HUNT}) begin
            errors++;
            $display("FAIL reset_async_slip got %h/%0d exp 0/%0d", act_a, state_a, ST_HUNT);
        end
        @(negedge clk_a);
        rst_a = 1'b0;
        model_reset(0);
        // Reset a few cycles into SLIP_WAIT.
        step_a(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) begin
            exp = exp_q_a.pop_front();
            if (i == 5) begin
                checks++;
                if (act_a !== exp || state_a !== ST_SLIP_WAIT) begin
                    errors++;
                    $display("FAIL reset_wait_pre got %h/%0d exp %h/%0d", act_a, state_a, exp, ST_SLIP_WAIT);
                end
            end
        end
        #1 rst_a = 1'b1;
        #1;
        checks++;
        if ({act_a, state_a} !== {19'd0, ST_HUNT}) begin
            errors++;
            $display("FAIL reset_async_wait got %h/%0d exp 0/%0d", act_a, state_a, ST_HUNT);
        end
        @(negedge clk_a);
        rst_a = 1'b0;
        model_reset(0);
        for (int i = 0; i < A_G; i++) begin
            step_a(1'b1, 1'b0);
            exp = exp_q_a.pop_front();
            checks++;
            if (act_a !== exp) begin
                errors++;
                $display("FAIL reset_recover cyc %0d got %h exp %h", i, act_a, exp);
            end
        end
    endtask

    task automatic test_random_traffic();
        logic [18:0] exp;
        int bad_div[4] = '{0, 200, 40, 6};
        reset_a();
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 700; i++) begin
                bit v, b;
                v = ($urandom_range(0, 9) != 0);
                b = (bad_div[ph] != 0) && ($urandom_range(1, bad_div[ph]) == 1);
                step_a(v, b);
                exp = exp_q_a.pop_front();
                checks++;
                if (act_a !== exp) begin
                    errors++;
                    $display("FAIL random ph %0d cyc %0d got %h exp %h", ph, i, act_a, exp);
                end
            end
        end
    endtask

    task automatic test_boundary_priority();
        logic [18:0] exp;
        bit pat_v[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        bit pat_b[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        reset_b();
        // 2 good -> lock; 4 good close a clean window; 3 good + bad as 4th.
        for (int i = 0; i < 10; i++) begin
            step_b(pat_v[i], pat_b[i]);
            exp = exp_q_b.pop_front();
            checks++;
            if (act_b !== exp) begin
                errors++;
                $display("FAIL priority cyc %0d got %h exp %h", i, act_b, exp);
            end
            if (i >= 1 && i < 9) begin
                checks++;
                if (block_lock_b !== 1'b1) begin
                    errors++;
                    $display("FAIL priority_hold cyc %0d got %b exp 1", i, block_lock_b);
                end
            end
        end
        checks++;
        if ({block_lock_b, lock_lost_b, slip_b, state_b} !== {1'b0, 1'b1, 1'b1, ST_SLIP_WAIT}) begin
            errors++;
            $display("FAIL priority_unlock got lock=%b lost=%b slip=%b st=%0d exp 0/1/1/%0d",
                     block_lock_b, lock_lost_b, slip_b, state_b, ST_SLIP_WAIT);
        end
    endtask

    task automatic test_saturation();
        logic [18:0] exp;
        // Constant bad headers: one slip every SLIP_WAIT+1 cycles.
        for (int i = 0; i < 2 * 65536 + 8; i++) begin
            step_b(1'b1, 1'b1);
            exp = exp_q_b.pop_front();
            checks++;
            if (act_b !== exp) begin
                errors++;
                $display("FAIL saturation cyc %0d got %h exp %h", i, act_b, exp);
            end
        end
        checks++;
        if (slip_count_b !== 16'hFFFF) begin
            errors++;
            $display("FAIL saturation_final got %h exp ffff", slip_count_b);
        end
    endtask

    initial begin
        model_reset(0);
        model_reset(1);
        test_reset();
        test_lock_acquire();
        test_loss_of_lock();
        test_hunt_slip();
        test_window_reset();
        test_reset_mid_wait();
        test_random_traffic();
        test_boundary_priority();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_block_lock_fsm.md
# rx_block_lock_fsm

Receive-side block-alignment controller for the 128b/130b decoder. Watches per-block sync-header status from the decoder and declares block lock after a run of valid headers. While unlocked, it requests one-bit alignment slips from the upstream bit aligner. While locked, it monitors the header error rate and drops lock when errors exceed a threshold within a window. Its `block_lock` output gates downstream consumption of decoded payload.

## Interface
Parameters:
- `GOOD_TO_LOCK`, 64 — consecutive valid headers required to declare lock (≥1)
- `WIN_SIZE`, 1024 — headers per error-monitoring window while locked (≥2)
- `BAD_TO_UNLOCK`, 16 — bad headers within one window that force loss of lock (1..WIN_SIZE)
- `SLIP_WAIT`, 16 — clock cycles to ignore headers after a slip (≥1)

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge
- `rst`  in  1  — asynchronous, active-high reset
- `hdr_valid`  in  1  — one 130-bit block's sync header is evaluated this cycle
- `hdr_bad`  in  1  — sync header was invalid (2'b00/2'b11); meaningful only with `hdr_valid`
- `slip`  out  1  — one-cycle pulse; aligner shifts block boundary by one bit
- `block_lock`  out  1  — block alignment achieved
- `lock_lost`  out  1  — one-cycle pulse when lock drops
- `slip_count`  out  16  — saturating count of slips since reset

## Operation
- States: HUNT, SLIP_WAIT, LOCKED. Reset state is HUNT.
- HUNT:
  - On `hdr_valid & !hdr_bad`, `good_cnt`++.
  - When the increment reaches `GOOD_TO_LOCK`, go to LOCKED, clear `win_cnt`/`bad_cnt`, and set `block_lock`.
  - On `hdr_valid & hdr_bad`, clear `good_cnt`, pulse `slip`, and go to SLIP_WAIT.
- SLIP_WAIT:
  - `wait_cnt` counts clock cycles, not headers. Header inputs are ignored entirely.
  - After `SLIP_WAIT` cycles in this state, go to HUNT with `good_cnt` = 0.
- LOCKED: each `hdr_valid` increments `win_cnt`; each bad header increments `bad_cnt`.
  - If `bad_cnt` reaches `BAD_TO_UNLOCK`: clear `block_lock`, pulse `lock_lost` and `slip`, and go to SLIP_WAIT.
  - Otherwise, if `win_cnt` reaches `WIN_SIZE`: clear both counters and stay LOCKED.
  - A header that both completes the window and hits the bad limit causes unlock; unlock has priority.
- `slip_count` increments on every `slip` pulse and saturates at 16'hFFFF.
- Counter widths are `$clog2(max+1)` of the respective parameter. No counter wraps.
- `hdr_bad` without `hdr_valid` is ignored in all states.

## Timing
- Reset values: state HUNT, all counters 0, `slip`=0, `block_lock`=0, `lock_lost`=0, `slip_count`=0.
- Outputs are registered, with 1-cycle latency from the qualifying header sample.
  - `block_lock` rises on the edge after the `GOOD_TO_LOCK`-th good header is sampled.
  - `slip` and `lock_lost` are high for exactly one cycle after the triggering header.
- SLIP_WAIT occupies exactly `SLIP_WAIT` cycles. The first header that can be counted in HUNT is sampled `SLIP_WAIT`+1 cycles after the `slip` cycle.
- Back-to-back `hdr_valid` (one header per cycle) is supported with no bubbles.
- Reset asserted mid-operation: all outputs clear asynchronously, and any in-flight `slip` pulse is dropped.

## Test plan
- Lock acquisition, default params: 64 consecutive good headers → `block_lock`=1 one cycle after the 64th; no `slip` pulses; `slip_count`=0.
- Hunt slip: 10 good headers, then 1 bad → a single `slip` pulse. Headers during the next 16 cycles are ignored. Lock then needs 64 new good headers; `slip_count`=1.
- Loss of lock: once locked, drive 16 bad headers spread within the first 1000 headers → `block_lock` falls, `lock_lost` and `slip` each pulse once, FSM enters SLIP_WAIT.
- Window reset: once locked, drive 15 bad headers in window 1 and 15 in window 2 (1024 headers each) → lock held throughout.
- Boundary priority: `BAD_TO_UNLOCK`=1, `WIN_SIZE`=4; drive 3 good headers then 1 bad as the 4th → unlock occurs, not a window clear.
- Reset mid-SLIP_WAIT, plus saturation: assert `rst` during SLIP_WAIT → all outputs 0 immediately, state HUNT. Force 65536 slips → `slip_count` holds at 16'hFFFF.
